crc_error_injector: RTL and testbench

Registered, parametrised error-injection stage between the CRC encoder output and the CRC checker input. Passes N+M-1-bit codewords over a valid/ready handshake and corrupts selected words with one of three runtime modes: single-bit, burst, or pseudo-random single-bit. Injection rate is programmable, and corrupted words are counted, so link tests can measure checker detection coverage.

---
 rtl/crc_pkg.sv | 28 ++
 rtl/crc_error_injector_if.sv | 28 ++
 rtl/crc_error_injector_lfsr.sv | 42 ++++
 rtl/crc_error_injector.sv | 148 ++++++++++++++
 tb/tb_crc_error_injector.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_pkg.sv
// ---------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the CRC error-injection stage:
//   inj_mode_e   - runtime injection mode encoding
//   LFSR_RESET   - LFSR state after reset
//   LFSR_TAPS    - Fibonacci tap mask for x^16 + x^14 + x^13 + x^11 + 1
//   calc_w()     - codeword width from message width N and polynomial width M
// ---------------------------------------------------------------------------
package crc_pkg;

    typedef enum logic [1:0] {
        INJ_OFF    = 2'd0,
        INJ_SINGLE = 2'd1,
        INJ_BURST  = 2'd2,
        INJ_RANDOM = 2'd3
    } inj_mode_e;

    localparam logic [15:0] LFSR_RESET = 16'hACE1;

    // Exponents 16, 14, 13, 11 map to state bits 15, 13, 12, 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // The codeword is the N-bit message followed by the (M-1)-bit remainder.
    function automatic int calc_w(input int n, input int m);
        return n + m - 1;
    endfunction

endpackage

// File: rtl/crc_error_injector_if.sv
// ---------------------------------------------------------------------------
// crc_error_injector_if
// Codeword stream around the injector: upstream valid/ready/data from the
// encoder and downstream valid/ready/data/err towards the checker.
//   master - the side that supplies codewords and consumes the output
//   slave  - the injector itself
// ---------------------------------------------------------------------------
interface crc_error_injector_if #(
    parameter int W = 15
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/crc_error_injector_lfsr.sv
// ---------------------------------------------------------------------------
// inj_lfsr
// Fibonacci LFSR supplying pseudo-random flip positions.
//   clk, rst_n  - clock, synchronous active-low reset (state -> RESET_VAL)
//   seed_load   - load seed (zero seed replaced by 1); wins over advance
//   advance     - step the register once
//   seed        - seed value
//   state       - current register contents
// ---------------------------------------------------------------------------
module inj_lfsr
    import crc_pkg::*;
#(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] RESET_VAL = LFSR_RESET,
    parameter logic [LFSR_W-1:0] TAPS      = LFSR_TAPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic              advance,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic              feedback;

    assign feedback = ^(state_q & TAPS);
    assign state    = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RESET_VAL;
        end else if (seed_load) begin
            // An all-zero state would lock the register up.
            state_q <= (seed == '0) ? LFSR_W'(1) : seed;
        end else if (advance) begin
            state_q <= {state_q[LFSR_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/crc_error_injector.sv
// ---------------------------------------------------------------------------
// crc_error_injector
// Registered stage between CRC encoder and checker that corrupts selected
// codewords (single-bit, clipped burst, or LFSR-chosen single bit) at a
// programmable rate and counts the corrupted words it emits.
//   clk, rst_n    - clock, synchronous active-low reset
//   bus (slave)   - in_valid/in_ready/in_data, out_valid/out_ready/out_data,
//                   out_err (set when out_data was corrupted)
//   mode          - 0 pass, 1 single-bit, 2 burst, 3 random single-bit
//   bit_pos       - flip position for modes 1 and 2
//   burst_len     - number of bits flipped in mode 2
//   period        - inject on every period-th accepted word (0 acts as 1)
//   seed/seed_load- LFSR seed and load strobe
//   inject_count  - saturating count of corrupted words emitted
// Mode, bit_pos, burst_len and period only matter on the accept cycle.
// ---------------------------------------------------------------------------
module crc_error_injector
    import crc_pkg::*;
#(
    parameter  int N      = 11,
    parameter  int M      = 5,
    parameter  int CNT_W  = 16,
    parameter  int LFSR_W = 16,
    localparam int W      = calc_w(N, M),
    localparam int PW     = $clog2(W)
) (
    input  logic              clk,
    input  logic              rst_n,
    crc_error_injector_if.slave bus,
    input  logic [1:0]        mode,
    input  logic [PW-1:0]     bit_pos,
    input  logic [PW:0]       burst_len,
    input  logic [CNT_W-1:0]  period,
    input  logic [LFSR_W-1:0] seed,
    input  logic              seed_load,
    output logic [CNT_W-1:0]  inject_count
);

    inj_mode_e         mode_e;
    logic              accept;
    logic              hit;
    logic [CNT_W-1:0]  period_eff;
    logic [CNT_W-1:0]  word_cnt;
    logic [LFSR_W-1:0] lfsr_state;
    logic [PW-1:0]     lfsr_low;
    logic [PW-1:0]     lfsr_pos;
    logic [W-1:0]      mask;
    logic              lfsr_unused;

    logic              out_valid_q;
    logic [W-1:0]      out_data_q;
    logic              out_err_q;
    logic [CNT_W-1:0]  inject_cnt_q;

    // Builds the flip mask for a word that has been selected for injection.
    // A burst is clipped at the top of the word; positions past the word
    // simply never match, which also covers bit_pos >= W.
    function automatic logic [W-1:0] build_mask(
        input inj_mode_e     m,
        input logic [PW-1:0] pos,
        input logic [PW:0]   len,
        input logic [PW-1:0] rnd_pos
    );
        logic [W-1:0] mask_v;
        mask_v = '0;
        for (int i = 0; i < W; i++) begin
            case (m)
                INJ_SINGLE: mask_v[i] = (i == int'(pos));
                INJ_BURST:  mask_v[i] = (i >= int'(pos)) && (i < int'(pos) + int'(len));
                INJ_RANDOM: mask_v[i] = (i == int'(rnd_pos));
                default:    mask_v[i] = 1'b0;
            endcase
        end
        return mask_v;
    endfunction

    assign mode_e       = inj_mode_e'(mode);
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign period_eff   = (period == '0) ? CNT_W'(1) : period;
    assign hit          = (mode_e != INJ_OFF) && (word_cnt == period_eff - CNT_W'(1));

    // Only the low PW bits pick a position; the rest just feed the sequence.
    assign lfsr_low     = lfsr_state[PW-1:0];
    assign lfsr_unused  = ^lfsr_state[LFSR_W-1:PW];

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        lfsr_pos = lfsr_low;
        mask     = '0;
        // lfsr_low < 2^PW < 2W, so one subtraction folds it into range.
        if (int'(lfsr_low) >= W) begin
            lfsr_pos = PW'(int'(lfsr_low) - W);
        end
        if (hit) begin
            mask = build_mask(mode_e, bit_pos, burst_len, lfsr_pos);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_err_q    <= 1'b0;
            inject_cnt_q <= '0;
            word_cnt     <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.in_data ^ mask;
                out_err_q   <= |mask;
                if ((|mask) && (inject_cnt_q != '1)) begin
                    inject_cnt_q <= inject_cnt_q + CNT_W'(1);
                end
                if ((mode_e == INJ_OFF) || hit) begin
                    word_cnt <= '0;
                end else begin
                    word_cnt <= word_cnt + CNT_W'(1);
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Current word sees the pre-advance state; a simultaneous seed_load
    // therefore only affects the following word.
    inj_lfsr #(
        .LFSR_W (LFSR_W)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .advance   (accept),
        .seed      (seed),
        .state     (lfsr_state)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign inject_count  = inject_cnt_q;

endmodule

// File: tb/tb_crc_error_injector.sv
// ---------------------------------------------------------------------------
// tb_crc_error_injector
// Directed scenarios plus randomized traffic for crc_error_injector. The
// reference model tracks the output register, word counter, LFSR and
// injection count from the behavioural rules and is stepped alongside the
// DUT on every clock.
// ---------------------------------------------------------------------------
module tb_crc_error_injector;
    import crc_pkg::*;

    localparam int N      = 11;
    localparam int M      = 5;
    localparam int W      = 15;
    localparam int PW     = 4;
    localparam int CNT_W  = 16;
    localparam int LFSR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        mode;
    logic [PW-1:0]     bit_pos;
    logic [PW:0]       burst_len;
    logic [CNT_W-1:0]  period;
    logic [LFSR_W-1:0] seed;
    logic              seed_load;
    logic [CNT_W-1:0]  inject_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic              m_ov;
    logic [W-1:0]      m_od;
    logic              m_oe;
    int                m_inj;
    int                m_cnt;
    logic [LFSR_W-1:0] m_lfsr;

    crc_error_injector_if #(.W(W)) bus ();

    crc_error_injector #(
        .N      (N),
        .M      (M),
        .CNT_W  (CNT_W),
        .LFSR_W (LFSR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .mode         (mode),
        .bit_pos      (bit_pos),
        .burst_len    (burst_len),
        .period       (period),
        .seed         (seed),
        .seed_load    (seed_load),
        .inject_count (inject_count)
    );

    always #5 clk = ~clk;

    // One step of x^16 + x^14 + x^13 + x^11 + 1: feedback is the XOR of the
    // bits at the polynomial exponents, shifted in at the bottom.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        int   exps[4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (exps[k]) fb ^= s[exps[k] - 1];
        return {s[LFSR_W-2:0], fb};
    endfunction

    // Advances the model and the DUT by one clock; inputs must already be set.
    task automatic cycle();
        logic         acc;
        logic         hit;
        logic [W-1:0] mask;
        int           pe;
        int           p;
        acc  = rst_n && bus.in_valid && (!m_ov || bus.out_ready);
        pe   = (period == 0) ? 1 : int'(period);
        hit  = (mode != 2'd0) && (m_cnt == pe - 1);
        mask = '0;
        if (acc && hit) begin
            case (mode)
                2'd1: if (int'(bit_pos) < W) mask[int'(bit_pos)] = 1'b1;
                2'd2: for (int k = 0; k < int'(burst_len); k++)
                          if (int'(bit_pos) + k < W) mask[int'(bit_pos) + k] = 1'b1;
                2'd3: begin
                          p = int'(m_lfsr[PW-1:0]) % W;
                          mask[p] = 1'b1;
                      end
                default: mask = '0;
            endcase
        end
        @(posedge clk);
        if (!rst_n) begin
            m_ov = 1'b0; m_od = '0; m_oe = 1'b0; m_inj = 0; m_cnt = 0; m_lfsr = 16'hACE1;
        end else begin
            if (acc) begin
                m_ov = 1'b1;
                m_od = bus.in_data ^ mask;
                m_oe = (mask != 0);
                if (m_oe && m_inj < 65535) m_inj++;
                m_cnt = (mode == 2'd0 || hit) ? 0 : ((m_cnt + 1) % 65536);
            end else if (bus.out_ready) begin
                m_ov = 1'b0;
            end
            if (seed_load)  m_lfsr = (seed == 0) ? 16'h0001 : seed;
            else if (acc)   m_lfsr = lfsr_next(m_lfsr);
        end
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        seed_load     = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 15'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0000", bus.out_data); end
        n_checks++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b want 0", bus.out_err); end
        n_checks++; if (inject_count !== 16'd0) begin n_fail++; $display("FAIL reset_inject_count: got %0d want 0", inject_count); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_pass_through();
        do_reset();
        mode = 2'd0; period = 16'd1;
        push(15'h1234);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL pass_valid: got %b want 1", bus.out_valid); end
        n_checks++; if (bus.out_data !== 15'h1234) begin n_fail++; $display("FAIL pass_data: got %h want 1234", bus.out_data); end
        n_checks++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL pass_err: got %b want 0", bus.out_err); end
        n_checks++; if (inject_count !== 16'd0) begin n_fail++; $display("FAIL pass_count: got %0d want 0", inject_count); end
    endtask

    task automatic test_single_bit();
        do_reset();
        mode = 2'd1; bit_pos = 4'd7; period = 16'd1;
        push(15'h0000);
        n_checks++; if (bus.out_data !== 15'h0080) begin n_fail++; $display("FAIL single_data: got %h want 0080", bus.out_data); end
        n_checks++; if (bus.out_err !== 1'b1) begin n_fail++; $display("FAIL single_err: got %b want 1", bus.out_err); end
        n_checks++; if (inject_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", inject_count); end
        bit_pos = 4'd15;
        push(15'h0000);
        n_checks++; if (bus.out_data !== 15'h0000) begin n_fail++; $display("FAIL single_oob_data: got %h want 0000", bus.out_data); end
        n_checks++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL single_oob_err: got %b want 0", bus.out_err); end
        n_checks++; if (inject_count !== 16'd1) begin n_fail++; $display("FAIL single_oob_count: got %0d want 1", inject_count); end
    endtask

    task automatic test_burst_clip();
        do_reset();
        mode = 2'd2; bit_pos = 4'd12; burst_len = 5'd5; period = 16'd1;
        push(15'h0000);
        n_checks++; if (bus.out_data !== 15'h7000) begin n_fail++; $display("FAIL burst_clip_data: got %h want 7000", bus.out_data); end
        n_checks++; if (bus.out_err !== 1'b1) begin n_fail++; $display("FAIL burst_clip_err: got %b want 1", bus.out_err); end
        bit_pos = 4'd3; burst_len = 5'd4;
        push(15'h7FFF);
        n_checks++; if (bus.out_data !== 15'h7F87) begin n_fail++; $display("FAIL burst_mid_data: got %h want 7f87", bus.out_data); end
        burst_len = 5'd0;
        push(15'h2222);
        n_checks++; if (bus.out_data !== 15'h2222) begin n_fail++; $display("FAIL burst_zero_data: got %h want 2222", bus.out_data); end
        n_checks++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL burst_zero_err: got %b want 0", bus.out_err); end
        n_checks++; if (inject_count !== 16'd2) begin n_fail++; $display("FAIL burst_count: got %0d want 2", inject_count); end
    endtask

    task automatic test_period();
        logic [W-1:0] want[4] = '{15'h0000, 15'h0000, 15'h0001, 15'h0000};
        do_reset();
        mode = 2'd1; bit_pos = 4'd0; period = 16'd3;
        for (int i = 0; i < 4; i++) begin
            push(15'h0000);
            n_checks++; if (bus.out_data !== want[i]) begin n_fail++; $display("FAIL period3_word%0d: got %h want %h", i, bus.out_data, want[i]); end
        end
        n_checks++; if (inject_count !== 16'd1) begin n_fail++; $display("FAIL period3_count: got %0d want 1", inject_count); end
        do_reset();
        period = 16'd0;
        for (int i = 0; i < 2; i++) begin
            push(15'h0000);
            n_checks++; if (bus.out_data !== 15'h0001) begin n_fail++; $display("FAIL period0_word%0d: got %h want 0001", i, bus.out_data); end
        end
    endtask

    task automatic test_random_backpressure();
        do_reset();
        seed = 16'h0001; seed_load = 1'b1;
        cycle();
        seed_load = 1'b0;
        mode = 2'd3; period = 16'd1;
        push(15'h0000);
        n_checks++; if (bus.out_data !== 15'h0002) begin n_fail++; $display("FAIL random_data: got %h want 0002", bus.out_data); end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 15'h0000;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++; if (bus.out_data !== 15'h0002) begin n_fail++; $display("FAIL stall%0d_data: got %h want 0002", i, bus.out_data); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall%0d_in_ready: got %b want 0", i, bus.in_ready); end
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall%0d_valid: got %b want 1", i, bus.out_valid); end
        end
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        // LFSR stepped exactly once from 0001 -> position 2.
        n_checks++; if (bus.out_data !== 15'h0004) begin n_fail++; $display("FAIL after_stall_data: got %h want 0004", bus.out_data); end
        n_checks++; if (inject_count !== 16'd2) begin n_fail++; $display("FAIL after_stall_count: got %0d want 2", inject_count); end
        cycle();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_seed_collision();
        logic [W-1:0] want[3] = '{15'h0002, 15'h0002, 15'h0004};
        do_reset();
        mode = 2'd3; period = 16'd1;
        seed = 16'h0000; seed_load = 1'b1;
        push(15'h0000);
        seed_load = 1'b0;
        n_checks++; if (bus.out_data !== want[0]) begin n_fail++; $display("FAIL collide_word0: got %h want %h", bus.out_data, want[0]); end
        for (int i = 1; i < 3; i++) begin
            push(15'h0000);
            n_checks++; if (bus.out_data !== want[i]) begin n_fail++; $display("FAIL collide_word%0d: got %h want %h", i, bus.out_data, want[i]); end
        end
    endtask

    task automatic test_reset_mid_operation();
        do_reset();
        mode = 2'd1; bit_pos = 4'd0; period = 16'd3;
        for (int i = 0; i < 16; i++) push(15'h0000);
        n_checks++; if (inject_count !== 16'd5) begin n_fail++; $display("FAIL midrst_pre_count: got %0d want 5", inject_count); end
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b want 1", bus.out_valid); end
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (inject_count !== 16'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", inject_count); end
        n_checks++; if (bus.out_data !== 15'h0000) begin n_fail++; $display("FAIL midrst_data: got %h want 0000", bus.out_data); end
        // Word counter back at 0: first word skipped; LFSR back at ACE1:
        // second word uses ACE1 stepped once (59C3) -> position 3.
        mode = 2'd3; period = 16'd2;
        push(15'h0000);
        n_checks++; if (bus.out_data !== 15'h0000) begin n_fail++; $display("FAIL midrst_cnt_data: got %h want 0000", bus.out_data); end
        push(15'h0000);
        n_checks++; if (bus.out_data !== 15'h0008) begin n_fail++; $display("FAIL midrst_lfsr_data: got %h want 0008", bus.out_data); end
        n_checks++; if (inject_count !== 16'd1) begin n_fail++; $display("FAIL midrst_post_count: got %0d want 1", inject_count); end
    endtask

    task automatic test_random_traffic();
        for (int blk = 0; blk < 10; blk++) begin
            do_reset();
            mode   = 2'($urandom_range(0, 3));
            period = 16'($urandom_range(0, 4));
            for (int c = 0; c < 25; c++) begin
                bit_pos       = 4'($urandom_range(0, 15));
                burst_len     = 5'($urandom_range(0, 20));
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.in_data   = 15'($urandom);
                bus.out_ready = ($urandom_range(0, 3) != 0);
                seed_load     = ($urandom_range(0, 9) == 0);
                seed          = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
                cycle();
                n_checks++; if (bus.out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_valid b%0d c%0d: got %b want %b", blk, c, bus.out_valid, m_ov); end
                if (m_ov) begin
                    n_checks++; if (bus.out_data !== m_od) begin n_fail++; $display("FAIL rnd_data b%0d c%0d: got %h want %h", blk, c, bus.out_data, m_od); end
                    n_checks++; if (bus.out_err !== m_oe) begin n_fail++; $display("FAIL rnd_err b%0d c%0d: got %b want %b", blk, c, bus.out_err, m_oe); end
                end
                n_checks++; if (int'(inject_count) !== m_inj) begin n_fail++; $display("FAIL rnd_count b%0d c%0d: got %0d want %0d", blk, c, inject_count, m_inj); end
                n_checks++; if (bus.in_ready !== (!m_ov || bus.out_ready)) begin n_fail++; $display("FAIL rnd_in_ready b%0d c%0d: got %b want %b", blk, c, bus.in_ready, !m_ov || bus.out_ready); end
            end
            seed_load = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        mode          = 2'd0;
        bit_pos       = '0;
        burst_len     = '0;
        period        = 16'd1;
        seed          = '0;
        seed_load     = 1'b0;
        m_ov = 1'b0; m_od = '0; m_oe = 1'b0; m_inj = 0; m_cnt = 0; m_lfsr = 16'hACE1;

        test_reset();
        test_pass_through();
        test_single_bit();
        test_burst_clip();
        test_period();
        test_random_backpressure();
        test_seed_collision();
        test_reset_mid_operation();
        test_random_traffic();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
